aq_djpeg_ycbcr_buffer: RTL

Ping-pong MCU buffer between the JPEG IDCT and the YCbCr->RGB converter. It collects the decoded 8x8 blocks of one MCU: up to four Y blocks plus one Cb and one Cr block, or four Y blocks for grayscale. It then offers the completed MCU to the colour converter and serves its sample reads through the converter's address handshake, replicating chroma for 4:2:2/4:4:0/4:2:0 subsampling. Two banks let the IDCT fill one MCU while the converter drains the other.

---
 rtl/aq_djpeg_ycbcr_buffer_if.sv | 50 +++++
 rtl/aq_djpeg_ycbcr_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_ycbcr_buffer_if.sv
// Bus bundle for the ping-pong YCbCr MCU buffer.
//   Write side (IDCT):    WrEnable/WrBlock/WrAddress/WrData sample strobe, WrMcuDone commit
//                         pulse with MCU metadata, WrReady back-pressure.
//   Read side (colour):   OutEnable offer plus read-bank metadata, InRead/InReadNext/InAddress
//                         address handshake, registered OutY/OutCb/OutCr samples.
// The slave modport is the buffer itself; the master modport is its surroundings.
interface aq_djpeg_ycbcr_buffer_if;
    logic               WrEnable;
    logic [2:0]         WrBlock;
    logic [5:0]         WrAddress;
    logic signed [8:0]  WrData;
    logic               WrMcuDone;
    logic [11:0]        WrBlockX;
    logic [11:0]        WrBlockY;
    logic [2:0]         WrComp;
    logic [1:0]         WrSamplingW;
    logic [1:0]         WrSamplingH;
    logic               WrReady;

    logic               OutEnable;
    logic [11:0]        OutBlockX;
    logic [11:0]        OutBlockY;
    logic [2:0]         OutComp;
    logic [1:0]         OutSamplingW;
    logic [1:0]         OutSamplingH;
    logic               InRead;
    logic               InReadNext;
    logic [7:0]         InAddress;
    logic signed [8:0]  OutY;
    logic signed [8:0]  OutCb;
    logic signed [8:0]  OutCr;

    modport slave (
        input  WrEnable, WrBlock, WrAddress, WrData, WrMcuDone,
        input  WrBlockX, WrBlockY, WrComp, WrSamplingW, WrSamplingH,
        output WrReady,
        output OutEnable, OutBlockX, OutBlockY, OutComp, OutSamplingW, OutSamplingH,
        input  InRead, InReadNext, InAddress,
        output OutY, OutCb, OutCr
    );

    modport master (
        output WrEnable, WrBlock, WrAddress, WrData, WrMcuDone,
        output WrBlockX, WrBlockY, WrComp, WrSamplingW, WrSamplingH,
        input  WrReady,
        input  OutEnable, OutBlockX, OutBlockY, OutComp, OutSamplingW, OutSamplingH,
        output InRead, InReadNext, InAddress,
        input  OutY, OutCb, OutCr
    );
endinterface

// File: rtl/aq_djpeg_ycbcr_buffer.sv
// Ping-pong MCU buffer between the JPEG IDCT and the YCbCr->RGB converter.
// One bank is filled by the IDCT (four Y 8x8 slots, one Cb and one Cr block) while the other
// is offered to and drained by the converter. Chroma is replicated on read for subsampled
// formats; grayscale MCUs return zero chroma.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - aq_djpeg_ycbcr_buffer_if.slave (write side, read side, metadata, samples)
module aq_djpeg_ycbcr_buffer (
    input  logic                          clk,
    input  logic                          rst,
    aq_djpeg_ycbcr_buffer_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StOffer, StActive} rd_state_e;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [2:0]  comp;
        logic [1:0]  sw;
        logic [1:0]  sh;
    } meta_t;

    // Storage: address MSB is the bank.
    logic signed [8:0] y_ram  [512];
    logic signed [8:0] cb_ram [128];
    logic signed [8:0] cr_ram [128];

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    rd_state_e         state_q, state_d;
    meta_t             meta_q [2];

    logic              wr_ready;
    logic              wr_fire;
    logic              commit;
    logic              rd_done;
    logic              out_enable;
    logic [1:0]        wr_slot;

    meta_t             rd_meta;
    logic [3:0]        rd_row;
    logic [3:0]        rd_col;
    logic [2:0]        c_row;
    logic [2:0]        c_col;
    logic [8:0]        y_rd_addr;
    logic [6:0]        c_rd_addr;
    logic              chroma_on;

    logic signed [8:0] out_y_q, out_cb_q, out_cr_q;

    assign wr_ready = !full_q[wr_bank_q];
    assign wr_fire  = bus.WrEnable  && wr_ready;
    assign commit   = bus.WrMcuDone && wr_ready;

    // Y slot for block ordinal n, depending on how many Y blocks the MCU carries.
    always_comb begin
        wr_slot = 2'd0;
        if (bus.WrComp == 3'd1 || bus.WrSamplingW == 2'd2) begin
            wr_slot = bus.WrBlock[1:0];
        end else if (bus.WrSamplingH == 2'd2) begin
            wr_slot = {bus.WrBlock[0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            case (bus.WrBlock)
                3'd0, 3'd1, 3'd2, 3'd3:
                    y_ram[{wr_bank_q, wr_slot, bus.WrAddress}] <= bus.WrData;
                3'd4:    cb_ram[{wr_bank_q, bus.WrAddress}] <= bus.WrData;
                3'd5:    cr_ram[{wr_bank_q, bus.WrAddress}] <= bus.WrData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q[0] <= '0;
            meta_q[1] <= '0;
        end else if (commit) begin
            meta_q[wr_bank_q] <= '{x: bus.WrBlockX, y: bus.WrBlockY, comp: bus.WrComp,
                                   sw: bus.WrSamplingW, sh: bus.WrSamplingH};
        end
    end

    // Read-side FSM and bank bookkeeping.
    always_comb begin
        state_d    = state_q;
        out_enable = 1'b0;
        rd_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) state_d = StOffer;
            end
            StOffer: begin
                out_enable = 1'b1;
                if (bus.InRead) state_d = StActive;
            end
            StActive: begin
                if (bus.InReadNext) begin
                    rd_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Commit and release can coincide; they always target different banks because a commit
    // needs an empty write bank and a release needs a full read bank.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Read address mapping: a 16x16 address space, Y tiled as 2x2 slots, chroma halved on
    // the subsampled axes.
    always_comb begin
        rd_meta   = meta_q[rd_bank_q];
        rd_row    = bus.InAddress[7:4];
        rd_col    = bus.InAddress[3:0];
        y_rd_addr = {rd_bank_q, rd_row[3], rd_col[3], rd_row[2:0], rd_col[2:0]};
        c_row     = (rd_meta.sh == 2'd2) ? rd_row[3:1] : rd_row[2:0];
        c_col     = (rd_meta.sw == 2'd2) ? rd_col[3:1] : rd_col[2:0];
        c_rd_addr = {rd_bank_q, c_row, c_col};
        chroma_on = (rd_meta.comp != 3'd1);
    end

    // The last read is captured at the release edge, so the freed bank can be refilled safely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_y_q  <= '0;
            out_cb_q <= '0;
            out_cr_q <= '0;
        end else if (bus.InRead) begin
            out_y_q  <= y_ram[y_rd_addr];
            out_cb_q <= chroma_on ? cb_ram[c_rd_addr] : 9'sd0;
            out_cr_q <= chroma_on ? cr_ram[c_rd_addr] : 9'sd0;
        end
    end

    assign bus.WrReady      = wr_ready;
    assign bus.OutEnable    = out_enable;
    assign bus.OutBlockX    = rd_meta.x;
    assign bus.OutBlockY    = rd_meta.y;
    assign bus.OutComp      = rd_meta.comp;
    assign bus.OutSamplingW = rd_meta.sw;
    assign bus.OutSamplingH = rd_meta.sh;
    assign bus.OutY         = out_y_q;
    assign bus.OutCb        = out_cb_q;
    assign bus.OutCr        = out_cr_q;

endmodule
